// File: rtl/pe_out_hf_bridge.sv
// pe_out_hf_bridge: receive-side bridge from the Gemmini PE output stream to a
// HazardFlow valid/ready payload. The PE side cannot stall, so each valid beat
// lands in a small circular FIFO. A beat that arrives when the FIFO is full and
// is not being drained is dropped, and a sticky overflow flag records the loss.
module pe_out_hf_bridge #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             io_in_valid,
  input  logic [7:0]       io_in_a,
  input  logic [19:0]      io_in_b,
  input  logic [19:0]      io_in_c,
  input  logic             io_in_control_dataflow,
  input  logic             io_in_control_propagate,
  input  logic [4:0]       io_in_control_shift,
  input  logic [2:0]       io_in_id,
  input  logic             io_in_last,
  output logic             out_output_payload_discriminant,
  output logic [7:0]       out_output_payload_Some_0_a,
  output logic [19:0]      out_output_payload_Some_0_b,
  output logic [19:0]      out_output_payload_Some_0_d,
  output logic             out_output_payload_Some_0_control_dataflow_discriminant,
  output logic             out_output_payload_Some_0_control_propagate_discriminant,
  output logic [4:0]       out_output_payload_Some_0_control_shift,
  output logic [2:0]       out_output_payload_Some_0_id,
  output logic             out_output_payload_Some_0_last,
  input  logic             out_output_resolver_ready,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] groups_pending,
  output logic             overflow
);

  localparam int PTR_W = $clog2(DEPTH);

  // One captured PE beat; c travels downstream as the d field.
  typedef struct packed {
    logic [7:0]  a;
    logic [19:0] b;
    logic [19:0] c;
    logic        dataflow;
    logic        propagate;
    logic [4:0]  shift;
    logic [2:0]  id;
    logic        last;
  } entry_t;

  entry_t             mem_q [DEPTH];
  entry_t             mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   groups_q, groups_d;
  logic               overflow_q, overflow_d;

  entry_t in_entry;
  entry_t head;
  logic   full;
  logic   push;
  logic   pop;
  logic   drop;

  // Next-state logic: handshake decode, pointer/count updates, drop detection.
  always_comb begin
    // NOTE: every variable gets a default at the top so no path leaves it unassigned (no latch).
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    groups_d   = groups_q;
    overflow_d = overflow_q;

    in_entry = '{a: io_in_a, b: io_in_b, c: io_in_c,
                 dataflow: io_in_control_dataflow,
                 propagate: io_in_control_propagate,
                 shift: io_in_control_shift, id: io_in_id, last: io_in_last};
    head = mem_q[rd_ptr_q];

    full = (count_q == CNT_W'(DEPTH));
    // Valid depends only on occupancy, so pop never loops back through ready.
    pop  = (count_q != '0) && out_output_resolver_ready;
    // A full FIFO still accepts a beat when the head leaves in the same cycle.
    push = io_in_valid && (!full || pop);
    drop = io_in_valid && full && !pop;

    if (push) begin
      mem_d[wr_ptr_q] = in_entry;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
    groups_d   = groups_q + CNT_W'(push && io_in_last) - CNT_W'(pop && head.last);
    overflow_d = overflow_q | drop;
  end

  // Control state: synchronous reset discards all queued entries and the flag.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      groups_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      groups_q   <= groups_d;
      overflow_q <= overflow_d;
    end
  end

  // Payload storage.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; count_q == 0 already marks every slot as invalid.
    mem_q <= mem_d;
  end

  assign out_output_payload_discriminant                          = (count_q != '0);
  assign out_output_payload_Some_0_a                              = head.a;
  assign out_output_payload_Some_0_b                              = head.b;
  assign out_output_payload_Some_0_d                              = head.c;
  assign out_output_payload_Some_0_control_dataflow_discriminant  = head.dataflow;
  assign out_output_payload_Some_0_control_propagate_discriminant = head.propagate;
  assign out_output_payload_Some_0_control_shift                  = head.shift;
  assign out_output_payload_Some_0_id                             = head.id;
  assign out_output_payload_Some_0_last                           = head.last;
  assign count          = count_q;
  assign groups_pending = groups_q;
  assign overflow       = overflow_q;

endmodule

// File: tb/tb_pe_out_hf_bridge.sv
// Testbench for pe_out_hf_bridge: a queue-based reference model tracks what the
// FIFO should hold; accepted beats are pushed into a scoreboard, and a monitor
// on the falling edge compares every handshaken payload and the status outputs.
module tb_pe_out_hf_bridge;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  typedef struct packed {
    logic [7:0]  a;
    logic [19:0] b;
    logic [19:0] c;
    logic        df;
    logic        pr;
    logic [4:0]  sh;
    logic [2:0]  id;
    logic        last;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  beat_t            in_beat;
  logic             ready;
  logic             out_valid;
  logic [7:0]       out_a;
  logic [19:0]      out_b;
  logic [19:0]      out_d;
  logic             out_df;
  logic             out_pr;
  logic [4:0]       out_sh;
  logic [2:0]       out_id;
  logic             out_last;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] groups_pending;
  logic             overflow;
  beat_t            out_beat;

  int checks = 0;
  int errors = 0;

  beat_t model_q[$];
  beat_t exp_q[$];
  bit    m_ovf = 1'b0;

  pe_out_hf_bridge #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk                             (clk),
    .rst                             (rst),
    .io_in_valid                     (in_valid),
    .io_in_a                         (in_beat.a),
    .io_in_b                         (in_beat.b),
    .io_in_c                         (in_beat.c),
    .io_in_control_dataflow          (in_beat.df),
    .io_in_control_propagate         (in_beat.pr),
    .io_in_control_shift             (in_beat.sh),
    .io_in_id                        (in_beat.id),
    .io_in_last                      (in_beat.last),
    .out_output_payload_discriminant (out_valid),
    .out_output_payload_Some_0_a     (out_a),
    .out_output_payload_Some_0_b     (out_b),
    .out_output_payload_Some_0_d     (out_d),
    .out_output_payload_Some_0_control_dataflow_discriminant  (out_df),
    .out_output_payload_Some_0_control_propagate_discriminant (out_pr),
    .out_output_payload_Some_0_control_shift (out_sh),
    .out_output_payload_Some_0_id    (out_id),
    .out_output_payload_Some_0_last  (out_last),
    .out_output_resolver_ready       (ready),
    .count                           (count),
    .groups_pending                  (groups_pending),
    .overflow                        (overflow)
  );

  assign out_beat = {out_a, out_b, out_d, out_df, out_pr, out_sh, out_id, out_last};

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_groups();
    int n = 0;
    foreach (model_q[i]) if (model_q[i].last) n++;
    return n;
  endfunction

  function automatic beat_t rand_beat();
    beat_t b;
    b.a    = 8'($urandom);
    b.b    = 20'($urandom);
    b.c    = 20'($urandom);
    b.df   = 1'($urandom);
    b.pr   = 1'($urandom);
    b.sh   = 5'($urandom);
    b.id   = 3'($urandom);
    b.last = 1'($urandom);
    return b;
  endfunction

  // Reference model: a FIFO of at most DEPTH beats that cannot refuse input.
  always @(posedge clk) begin
    if (rst) begin
      model_q.delete();
      exp_q.delete();
      m_ovf = 1'b0;
    end else begin
      if (model_q.size() != 0 && ready) void'(model_q.pop_front());
      if (in_valid) begin
        if (model_q.size() < DEPTH) begin
          model_q.push_back(in_beat);
          exp_q.push_back(in_beat);
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
  end

  // Monitor: status outputs every cycle, payload on every handshake.
  always @(negedge clk) begin
    if (!rst) begin
      check("valid", out_valid, model_q.size() != 0);
      check("count", count, model_q.size());
      check("groups_pending", groups_pending, model_groups());
      check("overflow", overflow, m_ovf);
      if (out_valid && ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pop", 1, 0);
        end else begin
          check("payload", out_beat, exp_q[0]);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    ready    = 1'b1;
    in_valid = 1'b0;
    for (int i = 0; i < budget && model_q.size() != 0; i++) step();
    check("drain_empty", count, 0);
  endtask

  initial begin
    beat_t single;
    rst      = 1'b1;
    in_valid = 1'b0;
    ready    = 1'b0;
    in_beat  = '0;
    repeat (3) step();
    rst = 1'b0;

    // Idle after reset with ready toggling.
    for (int i = 0; i < 5; i++) begin
      ready = 1'($urandom);
      step();
    end
    check("idle_count", count, 0);
    check("idle_valid", out_valid, 0);
    check("idle_overflow", overflow, 0);

    // Single beat with ready held high.
    single = '{a: 8'h5A, b: 20'h12345, c: 20'hFFFFF, df: 1'b0, pr: 1'b0,
               sh: 5'd3, id: 3'd5, last: 1'b1};
    ready    = 1'b1;
    in_valid = 1'b1;
    in_beat  = single;
    step();
    in_valid = 1'b0;
    check("single_valid", out_valid, 1);
    check("single_fields", out_beat, single);
    check("single_groups", groups_pending, 1);
    step();
    check("single_gone", out_valid, 0);
    check("single_groups_after", groups_pending, 0);

    // Streaming with ready high: occupancy never exceeds one.
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_beat  = rand_beat();
      step();
      check("stream_count_le1", count <= 1, 1);
    end
    drain(10);

    // Overflow: ready low, five beats into a four-entry FIFO.
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_beat  = rand_beat();
      step();
    end
    in_valid = 1'b0;
    check("ovf_count", count, 4);
    check("ovf_flag", overflow, 1);
    ready = 1'b1;
    repeat (4) step();
    check("ovf_drained", count, 0);
    check("ovf_sticky", overflow, 1);

    // Reset with three entries queued; beat and ready during reset are ignored.
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid     = 1'b1;
      in_beat      = rand_beat();
      in_beat.last = 1'b1;
      step();
    end
    check("pre_rst_groups", groups_pending, 3);
    rst      = 1'b1;
    in_valid = 1'b1;
    ready    = 1'b1;
    step();
    rst      = 1'b0;
    in_valid = 1'b0;
    check("rst_count", count, 0);
    check("rst_valid", out_valid, 0);
    check("rst_groups", groups_pending, 0);
    check("rst_overflow", overflow, 0);

    // Full FIFO with simultaneous push and pop over three pointer laps.
    ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b1;
      in_beat  = rand_beat();
      step();
    end
    ready = 1'b1;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      in_valid = 1'b1;
      in_beat  = rand_beat();
      step();
      check("full_pp_count", count, 4);
      check("full_pp_overflow", overflow, 0);
    end
    drain(10);

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 400; i++) begin
      rst      = ($urandom_range(0, 63) == 0);
      in_valid = 1'($urandom);
      ready    = ($urandom_range(0, 3) != 0) ? 1'($urandom) : 1'b0;
      in_beat  = rand_beat();
      step();
    end
    rst = 1'b0;
    drain(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pe_out_hf_bridge.md
# pe_out_hf_bridge

Receive-side bridge from the Gemmini-style PE output stream (valid-only `io_*` signals, no backpressure) into a HazardFlow valid/ready payload interface. It lets HazardFlow-generated consumers (accumulator/drain logic) sit downstream of a Chisel PE column. Each valid beat is captured into a small FIFO and presented as a HazardFlow `Some` payload. If the Gemmini side pushes into a full FIFO, the beat is dropped and a sticky overflow flag is raised, because that side cannot be stalled.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `CNT_W`, 3: width of occupancy count; equals log2(DEPTH)+1.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock.
- `rst` in 1: synchronous active-high reset.
- `io_in_valid` in 1: beat valid (Gemmini side).
- `io_in_a` in 8: row operand.
- `io_in_b` in 20: column operand.
- `io_in_c` in 20: partial sum.
- `io_in_control_dataflow` in 1: dataflow select.
- `io_in_control_propagate` in 1: propagate bit.
- `io_in_control_shift` in 5: shift amount.
- `io_in_id` in 3: tile id.
- `io_in_last` in 1: last beat of group.
- `out_output_payload_discriminant` out 1: HazardFlow valid (`Some`).
- `out_output_payload_Some_0_a` out 8: head entry field.
- `out_output_payload_Some_0_b` out 20: head entry field.
- `out_output_payload_Some_0_d` out 20: head entry field (carries `io_in_c`).
- `out_output_payload_Some_0_control_dataflow_discriminant` out 1: head entry field.
- `out_output_payload_Some_0_control_propagate_discriminant` out 1: head entry field.
- `out_output_payload_Some_0_control_shift` out 5: head entry field.
- `out_output_payload_Some_0_id` out 3: head entry field.
- `out_output_payload_Some_0_last` out 1: head entry field.
- `out_output_resolver_ready` in 1: consumer ready.
- `count` out CNT_W: current occupancy.
- `groups_pending` out CNT_W: entries in FIFO with `last`=1.
- `overflow` out 1: sticky; a beat was dropped.

## Operation
- Entry is a 59-bit packed word: a(8), b(20), c(20), dataflow, propagate, shift(5), id(3), last.
- Push = `io_in_valid && (count<DEPTH || pop)`.
- Pop = `out_output_payload_discriminant && out_output_resolver_ready`.
- Drop = `io_in_valid && count==DEPTH && !pop`; sets `overflow`, which is cleared only by `rst`. A dropped beat changes no other state.
- Storage: circular buffer with wr/rd pointers of log2(DEPTH) bits; pointers wrap modulo DEPTH.
- `count` += push − pop. `groups_pending` += (push && io_in_last) − (pop && head.last).
- `out_output_payload_discriminant` = (count != 0). Payload fields are driven from the head entry. They are don't-care when discriminant = 0, but must be stable while valid and not popped.
- No combinational path from `io_in_*` to outputs (no bypass). No path from `out_output_resolver_ready` to `io_*` (there is no upstream ready).
- HazardFlow rule: valid must not depend on ready. Once valid is asserted, the head remains until popped.

## Timing
- Reset (`rst`=1 at a clock edge): pointers=0, `count`=0, `groups_pending`=0, `overflow`=0, `out_output_payload_discriminant`=0. Any beat or pop during a reset cycle is ignored.
- Latency: a beat pushed at edge N is visible at the output after edge N (cycle N+1) if the FIFO was empty. Otherwise it is visible after all earlier entries pop.
- Throughput: 1 push and 1 pop per cycle sustained. With ready held at 1, output equals input delayed by 1 cycle.
- Full with simultaneous push and pop: both occur, `count` stays DEPTH, no overflow.
- Empty with push only: valid rises the next cycle. Ready is ignored while empty.
- Reset mid-stream: all entries are discarded, and `overflow` clears in the same cycle.

## Test plan
- Reset, then idle: `count`=0, discriminant=0, `overflow`=0; ready toggling has no effect.
- Single beat (a=0x5A, b=0x12345, c=0xFFFFF, shift=3, id=5, last=1) at cycle 10 with ready=1: output valid with identical fields at cycle 11 only; `groups_pending` is 1 for one cycle, then 0.
- Streaming 16 beats with ready=1: output sequence is identical and in order, delayed 1 cycle; `count` ≤1 throughout.
- Ready=0 and 5 beats pushed with DEPTH=4: first 4 are stored, `count`=4; 5th is dropped and `overflow`=1 from the next cycle. After ready=1, exactly 4 beats drain in order and `overflow` stays 1.
- Full FIFO, ready=1 and push in the same cycle: `count` stays 4, no overflow; the new beat appears 4 cycles later. Pointer wrap is verified over 3 full laps.
- `rst` asserted with 3 entries queued: the next cycle shows `count`=0, discriminant=0, `groups_pending`=0, `overflow`=0.
